// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module  : wb_regfile
// Brief   : Write-back select fused with the register file; two bypassed
//           combinational read ports and a one-cycle last-write history.
// Revision: 1.0
// ============================================================================
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [DATA_WIDTH-1:0] readMem_in,
  input  logic [DATA_WIDTH-1:0] ALUResult_in,
  input  logic [ADDR_WIDTH-1:0] WriteReg_in,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WriteData_out,
  output logic                  LastWriteValid,
  output logic [ADDR_WIDTH-1:0] LastWriteReg,
  output logic [DATA_WIDTH-1:0] LastWriteData
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_ZERO_REG = '0;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic                  last_valid_q, last_valid_d;
  logic [ADDR_WIDTH-1:0] last_reg_q,   last_reg_d;
  logic [DATA_WIDTH-1:0] last_data_q,  last_data_d;

  logic                  commit;
  logic                  bypass_ok;

  logic [1:0][ADDR_WIDTH-1:0] rd_idx;
  logic [1:0][DATA_WIDTH-1:0] rd_data;

  assign WriteData_out = MemtoReg ? readMem_in : ALUResult_in;
  assign commit        = RegWrite && (WriteReg_in != C_ZERO_REG);
  // Bypass is suppressed while reset is held so the read ports show all zeros.
  assign bypass_ok     = BYPASS_EN && commit && Rst;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (i != 0 && commit && WriteReg_in == ADDR_WIDTH'(i)) begin
        regs_d[i] = WriteData_out;
      end
    end
    regs_d[0] = '0;
  end

  always_comb begin
    last_valid_d = commit;
    last_reg_d   = commit ? WriteReg_in   : '0;
    last_data_d  = commit ? WriteData_out : '0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      last_valid_q <= 1'b0;
      last_reg_q   <= '0;
      last_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      last_valid_q <= last_valid_d;
      last_reg_q   <= last_reg_d;
      last_data_q  <= last_data_d;
    end
  end

  assign rd_idx = {ReadReg2, ReadReg1};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_data[k] = regs_q[rd_idx[k]];
      if (rd_idx[k] == C_ZERO_REG || !Rst) begin
        rd_data[k] = '0;
      end else if (bypass_ok && WriteReg_in == rd_idx[k]) begin
        rd_data[k] = WriteData_out;
      end
    end
  end

  assign ReadData1      = rd_data[0];
  assign ReadData2      = rd_data[1];
  assign LastWriteValid = last_valid_q;
  assign LastWriteReg   = last_reg_q;
  assign LastWriteData  = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_regfile
// Brief   : Table vectors, async-reset sequence and randomized traffic checked
//           against an array-based register-file model; bypass and no-bypass.
// Revision: 1.0
// ============================================================================
module tb_wb_regfile;

  logic        Clk;
  logic        Rst;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] readMem_in;
  logic [31:0] ALUResult_in;
  logic [4:0]  WriteReg_in;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;

  logic [31:0] rd1_b, rd2_b, wd_b, ld_b;
  logic [31:0] rd1_n, rd2_n, wd_n, ld_n;
  logic        lv_b, lv_n;
  logic [4:0]  lr_b, lr_n;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut_b (
    .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .readMem_in(readMem_in), .ALUResult_in(ALUResult_in), .WriteReg_in(WriteReg_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_b), .ReadData2(rd2_b),
    .WriteData_out(wd_b), .LastWriteValid(lv_b), .LastWriteReg(lr_b), .LastWriteData(ld_b)
  );

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_n (
    .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .readMem_in(readMem_in), .ALUResult_in(ALUResult_in), .WriteReg_in(WriteReg_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_n), .ReadData2(rd2_n),
    .WriteData_out(wd_n), .LastWriteValid(lv_n), .LastWriteReg(lr_n), .LastWriteData(ld_n)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain array plus last-write record.
  logic [31:0] mreg [32];
  logic        mlv;
  logic [4:0]  mlr;
  logic [31:0] mld;

  function automatic logic [31:0] m_wd();
    return MemtoReg ? readMem_in : ALUResult_in;
  endfunction

  function automatic logic m_commit();
    return RegWrite && (WriteReg_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
    if (!Rst || idx == 5'd0) return 32'd0;
    if (byp && m_commit() && WriteReg_in == idx) return m_wd();
    return mreg[idx];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mlv = 1'b0;
    mlr = 5'd0;
    mld = 32'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite     = rw;
    MemtoReg     = m2r;
    readMem_in   = mem;
    ALUResult_in = alu;
    WriteReg_in  = wr;
    ReadReg1     = r1;
    ReadReg2     = r2;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst) begin
      if (m_commit()) mreg[WriteReg_in] = m_wd();
      mlv = m_commit();
      mlr = m_commit() ? WriteReg_in : 5'd0;
      mld = m_commit() ? m_wd() : 32'd0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wd_b"},  wd_b,  m_wd());
    chk({tag, ".wd_n"},  wd_n,  m_wd());
    chk({tag, ".rd1_b"}, rd1_b, m_read(ReadReg1, 1'b1));
    chk({tag, ".rd2_b"}, rd2_b, m_read(ReadReg2, 1'b1));
    chk({tag, ".rd1_n"}, rd1_n, m_read(ReadReg1, 1'b0));
    chk({tag, ".rd2_n"}, rd2_n, m_read(ReadReg2, 1'b0));
    chk({tag, ".lv_b"},  32'(lv_b), 32'(mlv));
    chk({tag, ".lr_b"},  32'(lr_b), 32'(mlr));
    chk({tag, ".ld_b"},  ld_b,  mld);
    chk({tag, ".lv_n"},  32'(lv_n), 32'(mlv));
    chk({tag, ".ld_n"},  ld_n,  mld);
  endtask

  always @(posedge Clk) begin
    if (Rst === 1'b1 && $isunknown(RegWrite)) begin
      errors++;
      $display("FAIL regwrite_known: got %b required 0/1", RegWrite);
    end
  end

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e_wd;
    logic [31:0] e_b1;
    logic [31:0] e_b2;
    logic [31:0] e_n1;
    logic [31:0] e_n2;
    logic        e_lv;
    logic [4:0]  e_lr;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vt [8];

  initial begin
    //          rw    m2r   mem           alu           wr     r1     r2     wd            byp1          byp2          nob1          nob2          lv    lr     ld
    vt[0] = '{1'b1, 1'b0, 32'h0,        32'h0000_1234, 5'd8, 5'd8, 5'd0, 32'h0000_1234, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        1'b1, 5'd8, 32'h0000_1234};
    vt[1] = '{1'b0, 1'b1, 32'h0000_AAAA, 32'h0,       5'd8, 5'd8, 5'd9, 32'h0000_AAAA, 32'h0000_1234, 32'h0,        32'h0000_1234, 32'h0,        1'b0, 5'd0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,       5'd9, 5'd8, 5'd9, 32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0,        1'b1, 5'd9, 32'hDEAD_BEEF};
    vt[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd9, 5'd9, 5'd9, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0, 5'd0, 5'd8, 32'hFFFF_FFFF, 32'h0,        32'h0000_1234, 32'h0,        32'h0000_1234, 1'b0, 5'd0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h0,        32'd7,        5'd5, 5'd5, 5'd5, 32'd7,        32'd7,        32'd7,        32'h0,        32'h0,        1'b1, 5'd5, 32'd7};
    vt[6] = '{1'b1, 1'b0, 32'h0,        32'd11,       5'd5, 5'd5, 5'd5, 32'd11,       32'd11,       32'd11,       32'd7,        32'd7,        1'b1, 5'd5, 32'd11};
    vt[7] = '{1'b0, 1'b0, 32'h0,        32'h77,       5'd5, 5'd5, 5'd9, 32'h77,       32'd11,       32'hDEAD_BEEF, 32'd11,       32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0};
  end

  initial begin
    logic [4:0] wr;
    Rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    m_clear();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst.lv", 32'(lv_b), 32'd0);
    chk("rst.ld", ld_b, 32'd0);
    chk("rst.rd1", rd1_b, 32'd0);
    Rst = 1'b1;

    // Hand-computed vectors from a freshly reset file.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      drive(vt[i].rw, vt[i].m2r, vt[i].mem, vt[i].alu, vt[i].wr, vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("tbl%0d.wd", i),  wd_b,  vt[i].e_wd);
      chk($sformatf("tbl%0d.b1", i),  rd1_b, vt[i].e_b1);
      chk($sformatf("tbl%0d.b2", i),  rd2_b, vt[i].e_b2);
      chk($sformatf("tbl%0d.n1", i),  rd1_n, vt[i].e_n1);
      chk($sformatf("tbl%0d.n2", i),  rd2_n, vt[i].e_n2);
      tick();
      chk($sformatf("tbl%0d.lv_b", i), 32'(lv_b), 32'(vt[i].e_lv));
      chk($sformatf("tbl%0d.lr_b", i), 32'(lr_b), 32'(vt[i].e_lr));
      chk($sformatf("tbl%0d.ld_b", i), ld_b,      vt[i].e_ld);
      chk($sformatf("tbl%0d.lv_n", i), 32'(lv_n), 32'(vt[i].e_lv));
      chk($sformatf("tbl%0d.lr_n", i), 32'(lr_n), 32'(vt[i].e_lr));
      chk($sformatf("tbl%0d.ld_n", i), ld_n,      vt[i].e_ld);
    end

    // Async reset dropped mid-cycle while a write to r3 is pending.
    @(negedge Clk);
    drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3);
    #1;
    chk("ar.bypass", rd1_b, 32'h55);
    chk("ar.nobyp", rd1_n, 32'h0);
    tick();
    chk("ar.lv_pre", 32'(lv_b), 32'd1);
    chk("ar.stored", rd2_n, 32'h55);
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    m_clear();
    #1;
    chk("ar.lv_now", 32'(lv_b), 32'd0);
    chk("ar.lr_now", 32'(lr_b), 32'd0);
    chk("ar.ld_now", ld_b, 32'd0);
    chk("ar.r3_b", rd1_b, 32'd0);
    chk("ar.r3_n", rd2_n, 32'd0);
    chk("ar.wd_rst", wd_b, 32'h55);
    for (int i = 1; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(32 - i);
      #1;
      chk($sformatf("ar.sweep%0d.b", i), rd1_b, 32'd0);
      chk($sformatf("ar.sweep%0d.n", i), rd2_n, 32'd0);
    end
    @(negedge Clk);
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd8;
    #1;
    chk("ar.held_r3", rd1_n, 32'd0);
    chk("ar.held_r8", rd2_n, 32'd0);
    chk("ar.held_lv", 32'(lv_n), 32'd0);
    Rst = 1'b1;
    #1;
    chk("ar.rel_byp", rd1_b, 32'h55);
    chk("ar.rel_nob", rd1_n, 32'd0);
    tick();
    chk("ar.rel_store", rd1_n, 32'h55);
    chk("ar.rel_lv", 32'(lv_n), 32'd1);
    chk("ar.rel_lr", 32'(lr_n), 32'd3);

    // Randomized traffic against the model, with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      wr = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, wr,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
      #1;
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 39) == 0) begin
        Rst = 1'b0;
        m_clear();
        #1;
        check_model($sformatf("rnd%0d.rst", n));
        Rst = 1'b1;
        #1;
      end
      tick();
      chk($sformatf("rnd%0d.lv", n), 32'(lv_b), 32'(mlv));
      chk($sformatf("rnd%0d.lr", n), 32'(lr_b), 32'(mlr));
      chk($sformatf("rnd%0d.ld", n), ld_b, mld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage fused with the architectural register file; consumes the MEM/WB pipeline outputs.
- Selects the write-back data and commits it to a 32-entry register file on the rising clock edge.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Publishes a one-cycle registered history of the last committed write for the forwarding/hazard unit.

Parameters:
DATA_WIDTH, 32, width of data words and registers
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
BYPASS_EN, 1, 1 = same-cycle write-to-read bypass on read ports; 0 = read stored value only

Ports:
Clk  input  1  system clock, rising-edge
Rst  input  1  asynchronous, active-low reset
RegWrite  input  1  write enable from MEM/WB
MemtoReg  input  1  1 = write readMem_in, 0 = write ALUResult_in
readMem_in  input  DATA_WIDTH  load data from MEM/WB
ALUResult_in  input  DATA_WIDTH  ALU result from MEM/WB
WriteReg_in  input  ADDR_WIDTH  destination register index from MEM/WB
ReadReg1  input  ADDR_WIDTH  read port 1 index (ID stage)
ReadReg2  input  ADDR_WIDTH  read port 2 index (ID stage)
ReadData1  output  DATA_WIDTH  read port 1 data, combinational
ReadData2  output  DATA_WIDTH  read port 2 data, combinational
WriteData_out  output  DATA_WIDTH  current-cycle write-back data, combinational
LastWriteValid  output  1  registered: a write committed on the previous edge
LastWriteReg  output  ADDR_WIDTH  registered: index of that write
LastWriteData  output  DATA_WIDTH  registered: data of that write

Behaviour:
- One clock domain (Clk). Rst is asynchronous and active-low: while Rst=0, all registers and all Last* outputs are held at 0, independent of Clk.
- WriteData_out = MemtoReg ? readMem_in : ALUResult_in. Pure combinational; also valid during reset.
- Commit condition: commit = RegWrite && (WriteReg_in != 0).
- On each rising edge with Rst=1 and commit=1: reg[WriteReg_in] <= WriteData_out.
- reg[0] is hardwired to 0: never written, always reads 0, including via bypass.
- Read port k, for k = 1, 2:
  - ReadRegk == 0 -> ReadDatak = 0.
  - Else if BYPASS_EN=1, commit=1, and WriteReg_in == ReadRegk -> ReadDatak = WriteData_out (same-cycle bypass).
  - Else ReadDatak = reg[ReadRegk].
- During reset, ReadDatak = 0 for every index; bypass is suppressed.
- Both ports may address the same register; each port resolves independently.
- History registers, updated on each rising edge with Rst=1:
  - LastWriteValid <= commit.
  - LastWriteReg <= commit ? WriteReg_in : 0.
  - LastWriteData <= commit ? WriteData_out : 0.
  - These are zero on cycles with no commit, so the hazard unit needs no extra qualification.
- Latency: a write is visible through the bypass in the same cycle, in the storage array after 1 edge, and on the Last* outputs after 1 edge.
- Reset mid-operation: asserting Rst clears all state immediately. A write on the edge coinciding with Rst=0 is discarded. After Rst deasserts, the first commit takes effect on the next rising edge.
- MemtoReg is a don't-care when RegWrite=0; no state changes.
- Any X on RegWrite must not corrupt the array; the bench checks RegWrite is known whenever Rst=1.

Test Plan:
- Reset: Rst=0 after arbitrary writes -> ReadData1/2 = 0 for indices 1..31; LastWriteValid=0, LastWriteReg=0, LastWriteData=0.
- ALU write: RegWrite=1, MemtoReg=0, ALUResult_in=0x0000_1234, WriteReg_in=8, edge; then ReadReg1=8 -> ReadData1=0x0000_1234, LastWriteValid=1, LastWriteReg=8, LastWriteData=0x0000_1234.
- Load write plus bypass: RegWrite=1, MemtoReg=1, readMem_in=0xDEAD_BEEF, WriteReg_in=9, ReadReg2=9, before the edge -> ReadData2=0xDEAD_BEEF in the same cycle; after the edge with RegWrite=0 -> still 0xDEAD_BEEF. With BYPASS_EN=0, the pre-edge value is 0.
- $zero protection: RegWrite=1, WriteReg_in=0, ALUResult_in=0xFFFF_FFFF, edge -> ReadData1 (ReadReg1=0) = 0, LastWriteValid=0, LastWriteData=0.
- Dual port, same index: reg[5]=7, ReadReg1=ReadReg2=5 -> both ports = 7. Then write 11 to reg 5 with bypass -> both ports = 11 in the same cycle.
- Async reset mid-write: RegWrite=1, WriteReg_in=3, data 0x55; Rst drops to 0 between edges and is held across the next edge -> reg[3]=0 and LastWriteValid=0 immediately, without waiting for a Clk edge.
